timer_top: RTL and testbench
============================

Name: timer_top

Overview:
- APB-slave 64-bit free-running timer with a programmable power-of-two clock divider, a 64-bit compare, an interrupt output and debug-halt support.
- Sits on the peripheral APB bus. Software programs it through 8 word registers in a 12-bit address space.

Parameters:
- DIV_VAL_RST, 4'd1, reset value of TCR.div_val.
- CMP_RST, 32'hFFFF_FFFF, reset value of TCMP0 and TCMP1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tim_psel  input  1  APB select.
- tim_penable  input  1  APB enable (access phase).
- tim_pwrite  input  1  1 = write, 0 = read.
- tim_paddr  input  12  byte address; word-aligned.
- tim_pwdata  input  32  write data.
- tim_pstrb  input  4  byte write strobes.
- tim_prdata  output  32  read data.
- tim_pready  output  1  transfer complete.
- tim_pslverr  output  1  transfer error; valid only when tim_pready=1.
- dbg_mode  input  1  CPU in debug mode.
- tim_int  output  1  timer interrupt, level.

Behaviour:
- Registers (unmapped addresses read 0; writes to them are ignored with no error):
  - 0x00 TCR: [0] timer_en, [1] div_en, [11:8] div_val. Reset 0x0000_0100.
  - 0x04 TDR0: counter[31:0]. 0x08 TDR1: counter[63:32]. Both RW, reset 0.
  - 0x0C TCMP0, 0x10 TCMP1: compare[31:0] and [63:32]. RW, reset 0xFFFF_FFFF.
  - 0x14 TIER: [0] int_en. Reset 0.
  - 0x18 TISR: [0] int_st, write-1-to-clear. Reset 0.
  - 0x1C THCSR: [0] halt_req RW, [1] halt_ack RO. Reset 0.
  - All other bits are reserved: read 0, writes ignored.
- APB handshake:
  - Setup phase: psel=1, penable=0. Access phase: psel=1, penable=1.
  - tim_pready asserts in the first access-phase cycle after one wait state, i.e. the 2nd cycle with penable=1, and stays high for one cycle.
  - tim_pready is 0 at all other times; reset value 0.
  - A write commits at the clock edge where psel & penable & pwrite & pready.
  - Only bytes with pstrb[i]=1 are written.
  - tim_prdata is valid while pready=1 on reads, 0 otherwise; reset value 0.
- tim_pslverr=1 (with pready) and the whole write is discarded when a TCR write:
  - sets div_val > 8; or
  - changes div_en or div_val while timer_en=1.
  - All other accesses return pslverr=0.
- Counting:
  - Counter increments when timer_en=1 and the counter is not halted.
  - div_en=0 or div_val=0: +1 every clk.
  - Otherwise: +1 once every 2^div_val clks. An internal divider counter counts 0..2^div_val-1; the increment occurs on wrap.
  - First increment occurs on the edge after the cycle in which the enabling TCR write commits.
  - timer_en 1->0: counter holds its value; divider counter clears to 0.
  - 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFF -> 0, no flag.
  - A TDR0/TDR1 write in the same cycle as an increment: the written value wins.
- Interrupt:
  - int_st sets on any cycle where counter == {TCMP1,TCMP0}, regardless of int_en.
  - int_st clears only by writing 1 to TISR[0]. If set and clear occur in the same cycle, set wins.
  - tim_int = int_en & int_st, combinational from registers; reset value 0.
- Reset mid-operation: all registers, the divider, pready, pslverr and tim_int return to reset values asynchronously.

Optional Feature:
- Macro TIMER_DBG_HALT_EN.
- Defined:
  - halt_ack = halt_req & dbg_mode, registered.
  - While halt_ack=1, both the counter and the divider freeze; they resume on the next clk after halt_ack falls.
- Undefined:
  - THCSR reads 0 and writes are ignored.
  - dbg_mode is unused; counting never halts.

Test Plan:
- Reset, then read all 8 registers -> TCR=0x100, TDR0=TDR1=0, TCMP0=TCMP1=0xFFFFFFFF, TIER=TISR=THCSR=0; pslverr=0 on every access.
- Write TCR=0x1, wait 100 clks, write TCR=0x0, read TDR0 -> value equals the golden per-cycle count (100 ± the APB latency of the enabling/disabling writes); TDR1=0.
- Write TCR=0x302 (div_en=1, div_val=3), then TCR=0x303; run 80 clks -> counter advanced by 10. Then write TCR=0x901 -> pslverr=1 and TCR still reads 0x303.
- Write TDR0=0xFFFFFFF0, TDR1=0, TCMP0=0xFFFFFFFF, TCMP1=0, TIER=1, TCR=1 -> tim_int=1 within 16 clks; read TDR1=1 afterwards. Write TISR=1 -> tim_int=0.
- With TIMER_DBG_HALT_EN: counting, set dbg_mode=1, write THCSR=1 -> THCSR reads 0x3 and TDR0 is constant over 20 clks. Write THCSR=0 -> counting resumes.
- Write TDR0=0x12345678 with pstrb=4'b0011 -> TDR0 reads 0x00005678.

Source files
------------

// File: rtl/timer_top.sv
// timer_top -- APB slave 64-bit free-running timer.
//
// Purpose: 64-bit up-counter with an optional power-of-two prescaler,
// a 64-bit compare raising a sticky status bit, a level interrupt and
// optional debug-halt support.
//
// Optional feature macro: TIMER_DBG_HALT_EN
//   defined   -> THCSR.halt_req / halt_ack implemented, dbg_mode freezes
//                counter and divider while halt_ack=1
//   undefined -> THCSR reads 0, writes ignored, dbg_mode unused
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tim_psel/penable/pwrite    APB control
//   tim_paddr[11:0]            byte address (word aligned)
//   tim_pwdata[31:0]           write data
//   tim_pstrb[3:0]             byte write strobes
//   tim_prdata[31:0]           read data (0 unless a read completes)
//   tim_pready                 one-cycle completion, one wait state
//   tim_pslverr                error on illegal TCR writes
//   dbg_mode                   CPU debug mode
//   tim_int                    level interrupt = int_en & int_st
//
// Register map: 0x00 TCR, 0x04 TDR0, 0x08 TDR1, 0x0C TCMP0, 0x10 TCMP1,
//               0x14 TIER, 0x18 TISR (W1C), 0x1C THCSR.
module timer_top #(
  parameter logic [3:0]  DIV_VAL_RST = 4'd1,
  parameter logic [31:0] CMP_RST     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic [31:0] tim_prdata,
  output logic        tim_pready,
  output logic        tim_pslverr,
  input  logic        dbg_mode,
  output logic        tim_int
);

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] wd,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = strb[i] ? wd[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  logic        timer_en_q, div_en_q, int_en_q, int_st_q, int_st_d;
  logic [3:0]  div_val_q;
  logic [63:0] cnt_q, cnt_d, cmp_q;
  logic [7:0]  divcnt_q, divcnt_d;
  logic        pready_q, pready_d;
  logic        halt_req_q, halt_ack_q;

  // ---------------- APB decode ----------------
  logic        acc, wr, addr_ok, tcr_err;
  logic [2:0]  idx;
  logic [7:0]  wsel;
  logic [31:0] tcr_rd, tcr_new, rdata;

  assign acc      = tim_psel & tim_penable & pready_q;
  assign wr       = acc & tim_pwrite;
  assign addr_ok  = (tim_paddr[11:5] == 7'd0);
  assign idx      = tim_paddr[4:2];
  assign wsel     = (wr && addr_ok) ? (8'd1 << idx) : 8'd0;
  assign tcr_rd   = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
  assign tcr_new  = merge(tcr_rd, tim_pwdata, tim_pstrb);

  // Prescaler settings are frozen while the timer runs; out-of-range
  // div_val is rejected at any time. A rejected write changes nothing.
  assign tcr_err  = (tcr_new[11:8] > 4'd8) ||
                    (timer_en_q && ((tcr_new[1] != div_en_q) || (tcr_new[11:8] != div_val_q)));

  // Second access-phase cycle: pready rises after one wait state.
  assign pready_d = tim_psel & tim_penable & ~pready_q;

  always_comb begin
    rdata = 32'd0;
    if (addr_ok) begin
      case (idx)
        3'd0: rdata = tcr_rd;
        3'd1: rdata = cnt_q[31:0];
        3'd2: rdata = cnt_q[63:32];
        3'd3: rdata = cmp_q[31:0];
        3'd4: rdata = cmp_q[63:32];
        3'd5: rdata = {31'd0, int_en_q};
        3'd6: rdata = {31'd0, int_st_q};
        3'd7: rdata = {30'd0, halt_ack_q, halt_req_q};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign tim_pready  = pready_q;
  assign tim_prdata  = (acc && !tim_pwrite) ? rdata : 32'd0;
  assign tim_pslverr = wsel[0] & tcr_err;
  assign tim_int     = int_en_q & int_st_q;

  // ---------------- counter / divider ----------------
  logic        inc, use_div, div_last;
  logic [8:0]  div_top;
  logic [63:0] cnt_inc;

  assign use_div  = div_en_q & (div_val_q != 4'd0);
  assign div_top  = (9'd1 << div_val_q) - 9'd1;
  assign div_last = (divcnt_q == div_top[7:0]);
  assign cnt_inc  = cnt_q + {63'd0, inc};

  always_comb begin
    inc      = 1'b0;
    divcnt_d = divcnt_q;
    if (!timer_en_q) begin
      divcnt_d = 8'd0;
    end else if (!halt_ack_q) begin
      if (!use_div) begin
        inc = 1'b1;
      end else if (div_last) begin
        inc      = 1'b1;
        divcnt_d = 8'd0;
      end else begin
        divcnt_d = divcnt_q + 8'd1;
      end
    end
    // Software writes override the increment for the written bytes.
    cnt_d = cnt_inc;
    if (wsel[1]) cnt_d[31:0]  = merge(cnt_inc[31:0],  tim_pwdata, tim_pstrb);
    if (wsel[2]) cnt_d[63:32] = merge(cnt_inc[63:32], tim_pwdata, tim_pstrb);
    // Set has priority over a same-cycle W1C.
    int_st_d = int_st_q;
    if (wsel[6] && tim_pstrb[0] && tim_pwdata[0]) int_st_d = 1'b0;
    if (cnt_q == cmp_q)                           int_st_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= DIV_VAL_RST;
      cnt_q      <= 64'd0;
      cmp_q      <= {CMP_RST, CMP_RST};
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
      divcnt_q   <= 8'd0;
      pready_q   <= 1'b0;
    end else begin
      pready_q <= pready_d;
      cnt_q    <= cnt_d;
      divcnt_q <= divcnt_d;
      int_st_q <= int_st_d;
      if (wsel[0] && !tcr_err) begin
        timer_en_q <= tcr_new[0];
        div_en_q   <= tcr_new[1];
        div_val_q  <= tcr_new[11:8];
      end
      if (wsel[3]) cmp_q[31:0]  <= merge(cmp_q[31:0],  tim_pwdata, tim_pstrb);
      if (wsel[4]) cmp_q[63:32] <= merge(cmp_q[63:32], tim_pwdata, tim_pstrb);
      if (wsel[5] && tim_pstrb[0]) int_en_q <= tim_pwdata[0];
    end
  end

`ifdef TIMER_DBG_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_req_q <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      if (wsel[7] && tim_pstrb[0]) halt_req_q <= tim_pwdata[0];
      halt_ack_q <= halt_req_q & dbg_mode;
    end
  end
`else
  assign halt_req_q = 1'b0;
  assign halt_ack_q = 1'b0;
`endif

  // Bits deliberately left unconsumed.
  logic unused_ok;
  assign unused_ok = ^{dbg_mode, tim_paddr[1:0], tcr_new[31:12], tcr_new[7:2]};

endmodule

// File: tb/tb_timer_top.sv
module tb_timer_top;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, dbg_mode = 1'b0;
  logic [11:0] paddr = 12'd0;
  logic [31:0] pwdata = 32'd0;
  logic [3:0]  pstrb = 4'd0;
  logic [31:0] prdata;
  logic        pready, pslverr, tim_int;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_cmt;

  logic [31:0] rst_exp [8] = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  timer_top dut (
    .clk(clk), .rst_n(rst_n),
    .tim_psel(psel), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr),
    .dbg_mode(dbg_mode), .tim_int(tim_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; last_cmt is the cycle index of the committing edge.
  task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    n = 0;
    while (!pready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("pready_latency", 64'(n), 64'd1);
    last_rd  = prdata;
    last_err = pslverr;
    @(negedge clk);
    last_cmt = cyc;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'd0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [11:0] a);
    apb(1'b0, a, 32'd0, 4'h0);
  endtask

  initial begin
    logic [63:0] start, exp;
    logic [31:0] v, cfg;
    int e, dcy, run, dv, de, dv2, w, d;

    repeat (3) @(negedge clk);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_int", 64'(tim_int), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(12'(i * 4));
      check($sformatf("rst_reg%0d", i), 64'(last_rd), 64'(rst_exp[i]));
      check("rst_slverr", 64'(last_err), 64'd0);
    end

    // free running, no divider
    wr(12'h000, 32'h1); e = last_cmt;
    repeat (100) @(negedge clk);
    wr(12'h000, 32'h0); dcy = last_cmt - e;
    rd(12'h004); check("free_tdr0", 64'(last_rd), 64'(dcy));
    rd(12'h008); check("free_tdr1", 64'(last_rd), 64'd0);

    // divide by 8, illegal TCR while running
    wr(12'h004, 32'h0); wr(12'h008, 32'h0);
    wr(12'h000, 32'h302); check("div_cfg_err", 64'(last_err), 64'd0);
    wr(12'h000, 32'h303); e = last_cmt;
    repeat (80) @(negedge clk);
    wr(12'h000, 32'h901); check("div9_err", 64'(last_err), 64'd1);
    rd(12'h000); check("div9_tcr_kept", 64'(last_rd), 64'h303);
    wr(12'h000, 32'h302); dcy = last_cmt - e;
    rd(12'h004); check("div8_tdr0", 64'(last_rd), 64'(dcy) >> 3);

    // randomized runs vs. reference: count = start + floor(cycles / 2^d)
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 8);
      de = $urandom_range(0, 1);
      start = it[0] ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      wr(12'h000, 32'h0);
      wr(12'h004, start[31:0]);
      wr(12'h008, start[63:32]);
      cfg = 32'((dv << 8) | (de << 1));
      wr(12'h000, cfg); check("rnd_cfg_err", 64'(last_err), 64'd0);
      wr(12'h000, 32'(($urandom_range(9, 15) << 8) | (de << 1)));
      check("rnd_big_div_err", 64'(last_err), 64'd1);
      rd(12'h000); check("rnd_tcr_kept", 64'(last_rd), 64'(cfg));
      wr(12'h000, cfg | 32'h1); e = last_cmt;
      run = $urandom_range(20, 150);
      repeat (run / 2) @(negedge clk);
      dv2 = (dv + 1 + $urandom_range(0, 7)) % 9;
      wr(12'h000, 32'((dv2 << 8) | (de << 1) | 1));
      check("rnd_run_chg_err", 64'(last_err), 64'd1);
      rd(12'h000); check("rnd_run_tcr", 64'(last_rd), 64'(cfg | 32'h1));
      repeat (run / 2) @(negedge clk);
      wr(12'h000, cfg); dcy = last_cmt - e;
      check("rnd_dis_err", 64'(last_err), 64'd0);
      d = (de != 0 && dv != 0) ? dv : 0;
      exp = start + (64'(dcy) >> d);
      rd(12'h004); check($sformatf("rnd%0d_tdr0", it), 64'(last_rd), 64'(exp[31:0]));
      rd(12'h008); check($sformatf("rnd%0d_tdr1", it), 64'(last_rd), 64'(exp[63:32]));
    end

    // compare / interrupt across the 32-bit boundary
    wr(12'h000, 32'h0);
    wr(12'h004, 32'hFFFF_FFF0); wr(12'h008, 32'h0);
    wr(12'h00C, 32'hFFFF_FFFF); wr(12'h010, 32'h0);
    wr(12'h018, 32'h1);
    rd(12'h018); check("isr_cleared", 64'(last_rd), 64'd0);
    wr(12'h014, 32'h1);
    check("int_idle", 64'(tim_int), 64'd0);
    wr(12'h000, 32'h1);
    w = 0;
    while (!tim_int && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("int_latency", 64'(w), 64'd16);
    rd(12'h008); check("int_tdr1", 64'(last_rd), 64'd1);
    wr(12'h018, 32'h1);
    check("int_w1c", 64'(tim_int), 64'd0);
    wr(12'h000, 32'h0);

`ifdef TIMER_DBG_HALT_EN
    wr(12'h004, 32'h0); wr(12'h000, 32'h1);
    dbg_mode = 1'b1;
    wr(12'h01C, 32'h1);
    rd(12'h01C); check("halt_thcsr", 64'(last_rd), 64'h3);
    rd(12'h004); v = last_rd;
    repeat (20) @(negedge clk);
    rd(12'h004); check("halt_frozen", 64'(last_rd), 64'(v));
    wr(12'h01C, 32'h0);
    repeat (10) @(negedge clk);
    rd(12'h004); check("halt_resumed", 64'(last_rd > v), 64'd1);
    dbg_mode = 1'b0;
    wr(12'h000, 32'h0);
`else
    dbg_mode = 1'b1;
    wr(12'h01C, 32'h1);
    rd(12'h01C); check("thcsr_absent", 64'(last_rd), 64'd0);
    dbg_mode = 1'b0;
`endif

    // byte strobes
    wr(12'h004, 32'h0);
    apb(1'b1, 12'h004, 32'h1234_5678, 4'b0011);
    rd(12'h004); check("pstrb_tdr0", 64'(last_rd), 64'h5678);

    // unmapped address
    wr(12'h020, 32'hDEAD_BEEF); check("unmapped_err", 64'(last_err), 64'd0);
    rd(12'h020); check("unmapped_rd", 64'(last_rd), 64'd0);

    // reset mid-operation with interrupt asserted
    wr(12'h004, 32'h0); wr(12'h008, 32'h0);
    wr(12'h00C, 32'h5); wr(12'h010, 32'h0);
    wr(12'h018, 32'h1); wr(12'h014, 32'h1);
    wr(12'h000, 32'h1);
    repeat (10) @(negedge clk);
    check("pre_rst_int", 64'(tim_int), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_int", 64'(tim_int), 64'd0);
    check("async_rst_pready", 64'(pready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h000); check("mid_rst_tcr", 64'(last_rd), 64'h100);
    rd(12'h004); check("mid_rst_tdr0", 64'(last_rd), 64'd0);
    rd(12'h00C); check("mid_rst_tcmp0", 64'(last_rd), 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
